sha3_pad_stream: RTL and testbench

Streaming Keccak/SHA-3 padder. Accepts a byte-granular AXI-Stream message, passes data words through unchanged, and applies multi-rate pad10*1 with a configurable domain-separation byte. Emits whole rate-sized blocks of `RATE_WORDS` words, each word `8*BYTES` bits, toward the absorb stage. Generalises the fixed 64-bit last-word padder to arbitrary word width, arbitrary rate, domain suffix, extra-block generation and backpressure.

---
 rtl/sha3_pad_stream.sv | 197 +++++++++++++++++++
 tb/tb_sha3_pad_stream.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_pad_stream.sv
// ---------------------------------------------------------------------------
// sha3_pad_stream
//
// Streaming Keccak/SHA-3 padder. Message words pass straight through. The
// last beat is padded with pad10*1 using a configurable domain-separation
// byte. Zero words are then appended until the current rate block is
// complete, so the absorb stage always receives whole blocks of RATE_WORDS
// words.
//
// Parameters
//   BYTES      : bytes per word (data width is 8*BYTES)
//   RATE_WORDS : words per rate block (17 = SHA3-256, 9 = SHA3-512, 21 = SHAKE128)
//   DOMAIN     : first pad byte (06 = SHA3, 1F = SHAKE, 01 = Keccak)
//
// Ports
//   ACLK, ARESETN : clock (rising edge), asynchronous active-low reset
//   S_TDATA       : message word; byte 0 sits in the most significant byte
//   S_TVALID      : input beat valid
//   S_TREADY      : padder accepts an input beat
//   S_TLAST       : last beat of the message
//   S_TUSER       : valid byte count on the last beat (0..BYTES)
//   M_TDATA       : padded output word
//   M_TVALID      : output word valid
//   M_TREADY      : downstream accepts the word
//   M_TLAST       : last word of the final block of the message
//   M_TUSER       : last word of a rate block
// ---------------------------------------------------------------------------
module sha3_pad_stream #(
    parameter int         BYTES      = 8,
    parameter int         RATE_WORDS = 17,
    parameter logic [7:0] DOMAIN     = 8'h06
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [8*BYTES-1:0]           S_TDATA,
    input  logic                         S_TVALID,
    output logic                         S_TREADY,
    input  logic                         S_TLAST,
    input  logic [$clog2(BYTES+1)-1:0]   S_TUSER,
    output logic [8*BYTES-1:0]           M_TDATA,
    output logic                         M_TVALID,
    input  logic                         M_TREADY,
    output logic                         M_TLAST,
    output logic                         M_TUSER
);

    localparam int DW = 8 * BYTES;
    localparam int UW = $clog2(BYTES + 1);
    localparam int CW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;

    localparam logic [CW-1:0] LAST_IDX    = CW'(RATE_WORDS - 1);
    // 8'h80 in the final byte of a word (bits [7:0])
    localparam logic [DW-1:0] END_WORD    = DW'(8'h80);
    // DOMAIN in byte 0 of a word, everything else zero
    localparam logic [DW-1:0] DOMAIN_WORD = DW'(DOMAIN) << (DW - 8);

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_PADW = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   wcnt_n;
    logic [DW-1:0]   data_n;
    logic            valid_n;
    logic            last_n;
    logic            user_n;
    logic            load_en;
    logic            at_end;
    logic [CW-1:0]   wcnt_inc;

    // Keep bytes 0..n-1 of the last beat, place DOMAIN at byte n and clear
    // the rest. Called only with n < BYTES.
    function automatic logic [DW-1:0] pad_last(input logic [DW-1:0] data,
                                               input logic [UW-1:0] n);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (k < int'(n)) begin
                w[DW-1-8*k -: 8] = data[DW-1-8*k -: 8];
            end else if (k == int'(n)) begin
                w[DW-1-8*k -: 8] = DOMAIN;
            end
        end
        return w;
    endfunction

    // The output register can take a new word when it is empty or when its
    // current word is being handed off this cycle.
    assign load_en  = !M_TVALID || M_TREADY;

    // wcnt is the block position of the next word loaded into the output
    // register, so the word being loaded closes a block when wcnt hits the
    // last index.
    assign at_end   = (wcnt == LAST_IDX);
    assign wcnt_inc = at_end ? '0 : wcnt + CW'(1);

    // Input is only taken while streaming message data. Gating with ARESETN
    // keeps the handshake closed for the whole time reset is held.
    assign S_TREADY = ARESETN && (state == ST_DATA) && load_en;

    // Next-state and next-output-word logic. Every word that gets loaded
    // advances wcnt and carries M_TUSER when it closes a block; the state
    // decides which word (data, padded last beat, domain word or fill word)
    // is loaded.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        data_n  = M_TDATA;
        valid_n = M_TVALID;
        last_n  = M_TLAST;
        user_n  = M_TUSER;

        if (load_en) begin
            valid_n = 1'b0;
        end

        unique case (state)
            ST_DATA: begin
                if (S_TVALID && S_TREADY) begin
                    valid_n = 1'b1;
                    user_n  = at_end;
                    wcnt_n  = wcnt_inc;
                    last_n  = 1'b0;
                    data_n  = S_TDATA;
                    if (S_TLAST) begin
                        if (int'(S_TUSER) < BYTES) begin
                            // Room for DOMAIN in this word; if it also closes
                            // the block the final 1 bit lands here too.
                            data_n = pad_last(S_TDATA, S_TUSER)
                                     | (at_end ? END_WORD : '0);
                            last_n = at_end;
                            if (!at_end) begin
                                state_n = ST_FILL;
                            end
                        end else begin
                            // Full last word: padding needs a word of its own.
                            state_n = ST_PADW;
                        end
                    end
                end
            end

            ST_PADW: begin
                if (load_en) begin
                    valid_n = 1'b1;
                    user_n  = at_end;
                    wcnt_n  = wcnt_inc;
                    data_n  = DOMAIN_WORD | (at_end ? END_WORD : '0);
                    last_n  = at_end;
                    state_n = at_end ? ST_DATA : ST_FILL;
                end
            end

            ST_FILL: begin
                if (load_en) begin
                    valid_n = 1'b1;
                    user_n  = at_end;
                    wcnt_n  = wcnt_inc;
                    data_n  = at_end ? END_WORD : '0;
                    last_n  = at_end;
                    if (at_end) begin
                        state_n = ST_DATA;
                    end
                end
            end

            default: begin
                state_n = ST_DATA;
            end
        endcase
    end

    // State, block position and the single output register. Reset drops
    // any partially padded message.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= ST_DATA;
            wcnt     <= '0;
            M_TDATA  <= '0;
            M_TVALID <= 1'b0;
            M_TLAST  <= 1'b0;
            M_TUSER  <= 1'b0;
        end else begin
            state    <= state_n;
            wcnt     <= wcnt_n;
            M_TDATA  <= data_n;
            M_TVALID <= valid_n;
            M_TLAST  <= last_n;
            M_TUSER  <= user_n;
        end
    end

endmodule

// File: tb/tb_sha3_pad_stream.sv
// ---------------------------------------------------------------------------
// tb_sha3_pad_stream
//
// Self-checking bench for sha3_pad_stream with default parameters
// (BYTES=8, RATE_WORDS=17, DOMAIN=06). Messages are byte queues; the
// expected output stream is computed by padding the whole message as a byte
// array (append DOMAIN, zero to a block multiple, OR 80 into the final byte)
// and slicing it into words.
// ---------------------------------------------------------------------------
module tb_sha3_pad_stream;

    localparam int         BYTES = 8;
    localparam int         RW    = 17;
    localparam int         RB    = BYTES * RW;
    localparam logic [7:0] DOM   = 8'h06;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [63:0] S_TDATA;
    logic        S_TVALID;
    logic        S_TREADY;
    logic        S_TLAST;
    logic [3:0]  S_TUSER;
    logic [63:0] M_TDATA;
    logic        M_TVALID;
    logic        M_TREADY;
    logic        M_TLAST;
    logic        M_TUSER;

    int n_cmp = 0;
    int n_err = 0;

    // 0: always ready, 1: toggle every cycle, 2: random
    int ready_mode = 0;

    byte unsigned msg_q[$];
    logic [65:0]  exp_q[$];
    logic [65:0]  cap_q[$];

    int          stall_err  = 0;
    logic        stall_prev = 1'b0;
    logic [65:0] stall_word;

    sha3_pad_stream #(
        .BYTES      (BYTES),
        .RATE_WORDS (RW),
        .DOMAIN     (DOM)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .S_TDATA  (S_TDATA),
        .S_TVALID (S_TVALID),
        .S_TREADY (S_TREADY),
        .S_TLAST  (S_TLAST),
        .S_TUSER  (S_TUSER),
        .M_TDATA  (M_TDATA),
        .M_TVALID (M_TVALID),
        .M_TREADY (M_TREADY),
        .M_TLAST  (M_TLAST),
        .M_TUSER  (M_TUSER)
    );

    // Free-running 100 MHz clock.
    always #5 ACLK = ~ACLK;

    // Downstream ready pattern, updated just after each rising edge.
    always @(posedge ACLK) begin
        #1;
        case (ready_mode)
            0:       M_TREADY = 1'b1;
            1:       M_TREADY = ~M_TREADY;
            default: M_TREADY = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor on the falling edge: records every word that will be
    // handed off at the next rising edge and notes any stalled word that
    // changes or disappears before it is taken.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                if (!M_TVALID || ({M_TLAST, M_TUSER, M_TDATA} !== stall_word)) begin
                    stall_err++;
                end
            end
            if (M_TVALID && M_TREADY) begin
                cap_q.push_back({M_TLAST, M_TUSER, M_TDATA});
            end
            stall_prev = M_TVALID && !M_TREADY;
            stall_word = {M_TLAST, M_TUSER, M_TDATA};
        end
    end

    // Reference model: pad the message as a flat byte array, then cut it
    // into words with byte 0 in the top byte.
    function automatic void build_expected();
        int L;
        int total;
        byte unsigned p[];
        L     = msg_q.size();
        total = ((L + 1 + RB - 1) / RB) * RB;
        p     = new[total];
        for (int i = 0; i < total; i++) p[i] = 8'h00;
        for (int i = 0; i < L; i++) p[i] = msg_q[i];
        p[L]       = DOM;
        p[total-1] = p[total-1] | 8'h80;
        exp_q.delete();
        for (int w = 0; w < total / BYTES; w++) begin
            logic [63:0] d;
            for (int k = 0; k < BYTES; k++) d[63-8*k -: 8] = p[w*BYTES+k];
            exp_q.push_back({(w == total / BYTES - 1), ((w % RW) == RW - 1), d});
        end
    endfunction

    function automatic void make_random_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endfunction

    // Drive msg_q as AXI-Stream beats. Unused bytes of the last beat are
    // random so that masking is exercised. Returns ok=0 if a beat is never
    // accepted.
    task automatic send_message(input bit gaps, output bit ok);
        int L;
        int beats;
        bit hs;
        L     = msg_q.size();
        beats = (L == 0) ? 1 : (L + BYTES - 1) / BYTES;
        ok    = 1'b1;
        for (int b = 0; b < beats; b++) begin
            int n;
            int waited;
            n = (b == beats - 1) ? L - b * BYTES : BYTES;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    S_TVALID = 1'b0;
                    @(posedge ACLK);
                    #1;
                end
            end
            for (int k = 0; k < BYTES; k++) begin
                S_TDATA[63-8*k -: 8] = (k < n) ? msg_q[b*BYTES+k] : 8'($urandom);
            end
            S_TVALID = 1'b1;
            S_TLAST  = (b == beats - 1);
            S_TUSER  = S_TLAST ? 4'(n) : 4'($urandom_range(0, 8));
            waited   = 0;
            forever begin
                @(negedge ACLK);
                hs = S_TREADY;
                @(posedge ACLK);
                #1;
                if (hs) break;
                waited++;
                if (waited > 500) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (!ok) break;
        end
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
    endtask

    // Wait (bounded) for count captured words, then idle a while so that
    // any extra words would also be captured.
    task automatic wait_output(input int count);
        int t;
        t = 0;
        while (cap_q.size() < count && t < 5000) begin
            @(posedge ACLK);
            t++;
        end
        repeat (40) @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETN  = 1'b0;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        S_TUSER  = '0;
        S_TDATA  = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        n_cmp++; if (M_TVALID !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tvalid got %0b expected 0", M_TVALID); end
        n_cmp++; if (M_TDATA !== 64'h0) begin n_err++; $display("[TB] FAIL reset_tdata got %h expected 0", M_TDATA); end
        n_cmp++; if (M_TLAST !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tlast got %0b expected 0", M_TLAST); end
        n_cmp++; if (M_TUSER !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tuser got %0b expected 0", M_TUSER); end
        n_cmp++; if (S_TREADY !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tready_low got %0b expected 0", S_TREADY); end
        ARESETN = 1'b1;
        #1;
        n_cmp++; if (S_TREADY !== 1'b1) begin n_err++; $display("[TB] FAIL reset_tready_release got %0b expected 1", S_TREADY); end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_empty();
        bit ok;
        ready_mode = 0;
        msg_q.delete();
        build_expected();
        cap_q.delete();
        send_message(1'b0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL empty_accept got timeout expected handshake"); end
        wait_output(exp_q.size());
        n_cmp++; if (cap_q.size() != 17) begin n_err++; $display("[TB] FAIL empty_count got %0d expected 17", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL empty_w%0d got %h expected %h", i, cap_q[i], exp_q[i]); end
        end
        if (cap_q.size() >= 17) begin
            n_cmp++; if (cap_q[0] !== {2'b00, 64'h0600000000000000}) begin n_err++; $display("[TB] FAIL empty_w0_const got %h expected 0600000000000000", cap_q[0]); end
            n_cmp++; if (cap_q[16] !== {2'b11, 64'h0000000000000080}) begin n_err++; $display("[TB] FAIL empty_w16_const got %h expected 3_0000000000000080", cap_q[16]); end
        end
    endtask

    task automatic test_abc();
        bit ok;
        ready_mode = 0;
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
        build_expected();
        cap_q.delete();
        send_message(1'b0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL abc_accept got timeout expected handshake"); end
        wait_output(exp_q.size());
        n_cmp++; if (cap_q.size() != 17) begin n_err++; $display("[TB] FAIL abc_count got %0d expected 17", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL abc_w%0d got %h expected %h", i, cap_q[i], exp_q[i]); end
        end
        if (cap_q.size() >= 1) begin
            n_cmp++; if (cap_q[0][63:0] !== 64'h6162630600000000) begin n_err++; $display("[TB] FAIL abc_w0_const got %h expected 6162630600000000", cap_q[0][63:0]); end
        end
    endtask

    task automatic test_135_bytes();
        bit ok;
        ready_mode = 0;
        make_random_msg(128);
        for (int i = 1; i <= 7; i++) msg_q.push_back(8'(i));
        build_expected();
        cap_q.delete();
        send_message(1'b0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL b135_accept got timeout expected handshake"); end
        @(negedge ACLK);
        n_cmp++; if (S_TREADY !== 1'b1) begin n_err++; $display("[TB] FAIL b135_no_fill_tready got %0b expected 1", S_TREADY); end
        wait_output(exp_q.size());
        n_cmp++; if (cap_q.size() != 17) begin n_err++; $display("[TB] FAIL b135_count got %0d expected 17", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL b135_w%0d got %h expected %h", i, cap_q[i], exp_q[i]); end
        end
        if (cap_q.size() >= 17) begin
            n_cmp++; if (cap_q[16] !== {2'b11, 64'h0102030405060786}) begin n_err++; $display("[TB] FAIL b135_w16_const got %h expected 3_0102030405060786", cap_q[16]); end
        end
    endtask

    task automatic test_136_bytes();
        bit ok;
        int ready_high;
        ready_mode = 0;
        make_random_msg(136);
        build_expected();
        cap_q.delete();
        send_message(1'b0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL b136_accept got timeout expected handshake"); end
        ready_high = 0;
        repeat (17) begin
            @(negedge ACLK);
            if (S_TREADY) ready_high++;
        end
        n_cmp++; if (ready_high != 0) begin n_err++; $display("[TB] FAIL b136_pad_tready got %0d ready cycles expected 0", ready_high); end
        wait_output(exp_q.size());
        n_cmp++; if (cap_q.size() != 34) begin n_err++; $display("[TB] FAIL b136_count got %0d expected 34", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL b136_w%0d got %h expected %h", i, cap_q[i], exp_q[i]); end
        end
        if (cap_q.size() >= 18) begin
            n_cmp++; if (cap_q[16][65:64] !== 2'b01) begin n_err++; $display("[TB] FAIL b136_w16_flags got %b expected 01", cap_q[16][65:64]); end
            n_cmp++; if (cap_q[17] !== {2'b00, 64'h0600000000000000}) begin n_err++; $display("[TB] FAIL b136_w17_const got %h expected 0_0600000000000000", cap_q[17]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        ready_mode = 1;
        stall_err  = 0;
        make_random_msg(136);
        build_expected();
        cap_q.delete();
        send_message(1'b1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL bp_accept got timeout expected handshake"); end
        wait_output(exp_q.size());
        n_cmp++; if (cap_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL bp_count got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL bp_w%0d got %h expected %h", i, cap_q[i], exp_q[i]); end
        end
        n_cmp++; if (stall_err != 0) begin n_err++; $display("[TB] FAIL bp_stall_stable got %0d changes expected 0", stall_err); end
        ready_mode = 0;
    endtask

    task automatic test_reset_in_fill();
        bit ok;
        int t;
        ready_mode = 0;
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
        cap_q.delete();
        send_message(1'b0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL rstfill_accept got timeout expected handshake"); end
        t = 0;
        while (cap_q.size() < 5 && t < 1000) begin
            @(posedge ACLK);
            t++;
        end
        @(posedge ACLK);
        #2;
        ARESETN = 1'b0;
        #1;
        n_cmp++; if (M_TVALID !== 1'b0) begin n_err++; $display("[TB] FAIL rstfill_tvalid got %0b expected 0", M_TVALID); end
        n_cmp++; if (S_TREADY !== 1'b0) begin n_err++; $display("[TB] FAIL rstfill_tready got %0b expected 0", S_TREADY); end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        msg_q.delete();
        build_expected();
        cap_q.delete();
        send_message(1'b0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL rstfill_empty_accept got timeout expected handshake"); end
        wait_output(exp_q.size());
        n_cmp++; if (cap_q.size() != 17) begin n_err++; $display("[TB] FAIL rstfill_count got %0d expected 17", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL rstfill_w%0d got %h expected %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_messages();
        bit ok;
        int len;
        stall_err = 0;
        for (int m = 0; m < 8; m++) begin
            len        = $urandom_range(0, 300);
            ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            make_random_msg(len);
            build_expected();
            cap_q.delete();
            send_message(1'($urandom_range(0, 1)), ok);
            n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL rnd%0d_accept got timeout expected handshake", m); end
            wait_output(exp_q.size());
            n_cmp++; if (cap_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL rnd%0d_count len %0d got %0d expected %0d", m, len, cap_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
                n_cmp++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL rnd%0d_w%0d got %h expected %h", m, i, cap_q[i], exp_q[i]); end
            end
        end
        n_cmp++; if (stall_err != 0) begin n_err++; $display("[TB] FAIL rnd_stall_stable got %0d changes expected 0", stall_err); end
        ready_mode = 0;
    endtask

    // Test sequence.
    initial begin
        M_TREADY = 1'b1;
        $display("[TB] start");
        test_reset();
        test_empty();
        test_abc();
        test_135_bytes();
        test_136_bytes();
        test_backpressure();
        test_reset_in_fill();
        test_random_messages();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
